// File: rtl/operand_sequencer.sv
// Multi-cycle operand fetch / ALU execute / write-back sequencer for one parsed instruction.
// Optional memory/ALU wait watchdog enabled by defining OPERAND_SEQ_TIMEOUT_EN.
module operand_sequencer #(
    parameter int VALUE_WIDTH   = 16,
    parameter int OPCODE_WIDTH  = 6,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     instrValid,
    output logic                     instrReady,
    input  logic [OPCODE_WIDTH-1:0]  opCode,
    input  logic [ADDRESS_WIDTH-1:0] address1In,
    input  logic [ADDRESS_WIDTH-1:0] address2In,
    input  logic [ADDRESS_WIDTH-1:0] addressOut,
    input  logic [1:0]               address1Type,
    input  logic [1:0]               address2Type,
    input  logic [1:0]               outType,
    input  logic [7:0]               instructionValue,
    output logic [2:0]               regReadAddr,
    input  logic [VALUE_WIDTH-1:0]   regReadData,
    output logic                     regWe,
    output logic [2:0]               regWriteAddr,
    output logic [VALUE_WIDTH-1:0]   regWriteData,
    output logic                     memReq,
    output logic                     memWe,
    output logic [ADDRESS_WIDTH-1:0] memAddr,
    output logic [VALUE_WIDTH-1:0]   memWdata,
    input  logic                     memAck,
    input  logic [VALUE_WIDTH-1:0]   memRdata,
    output logic                     aluStart,
    output logic [OPCODE_WIDTH-1:0]  aluOp,
    output logic [VALUE_WIDTH-1:0]   opA,
    output logic [VALUE_WIDTH-1:0]   opB,
    input  logic                     aluDone,
    input  logic [VALUE_WIDTH-1:0]   aluResult,
    output logic                     busy,
    output logic                     error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_A_PTR   = 3'd1;
    localparam logic [2:0] S_A_FETCH = 3'd2;
    localparam logic [2:0] S_B_PTR   = 3'd3;
    localparam logic [2:0] S_B_FETCH = 3'd4;
    localparam logic [2:0] S_EXEC    = 3'd5;
    localparam logic [2:0] S_W_PTR   = 3'd6;
    localparam logic [2:0] S_W_WRITE = 3'd7;

    localparam logic [1:0] T_IMM = 2'b00;
    localparam logic [1:0] T_REG = 2'b01;
    localparam logic [1:0] T_IND = 2'b11;

    logic [2:0]               state_q, state_d, state_n;
    logic [OPCODE_WIDTH-1:0]  op_q, op_d;
    logic [ADDRESS_WIDTH-1:0] a1_q, a1_d, a2_q, a2_d, ao_q, ao_d;
    logic [1:0]               t1_q, t1_d, t2_q, t2_d, to_q, to_d;
    logic [7:0]               imm_q, imm_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [VALUE_WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [VALUE_WIDTH-1:0]   res_q, res_d;
    logic                     start_q, start_d;
    logic                     waiting, err_ill, timeout;
    logic [2:0]               b_entry;

    assign b_entry = (t2_q == T_IND) ? S_B_PTR : S_B_FETCH;

    always_comb begin
        state_n      = state_q;
        op_d         = op_q;
        a1_d         = a1_q;
        a2_d         = a2_q;
        ao_d         = ao_q;
        t1_d         = t1_q;
        t2_d         = t2_q;
        to_d         = to_q;
        imm_d        = imm_q;
        ptr_d        = ptr_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        res_d        = res_q;
        regReadAddr  = '0;
        regWe        = 1'b0;
        regWriteAddr = '0;
        regWriteData = '0;
        memReq       = 1'b0;
        memWe        = 1'b0;
        memAddr      = '0;
        memWdata     = '0;
        waiting      = 1'b0;
        err_ill      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (instrValid) begin
                    op_d    = opCode;
                    a1_d    = address1In;
                    a2_d    = address2In;
                    ao_d    = addressOut;
                    t1_d    = address1Type;
                    t2_d    = address2Type;
                    to_d    = outType;
                    imm_d   = instructionValue;
                    state_n = (address1Type == T_IND) ? S_A_PTR : S_A_FETCH;
                end
            end
            S_A_PTR: begin
                regReadAddr = a1_q[2:0];
                ptr_d       = regReadData[ADDRESS_WIDTH-1:0];
                state_n     = S_A_FETCH;
            end
            S_A_FETCH: begin
                case (t1_q)
                    T_IMM: begin
                        opa_d   = VALUE_WIDTH'(a1_q);
                        state_n = b_entry;
                    end
                    T_REG: begin
                        regReadAddr = a1_q[2:0];
                        opa_d       = regReadData;
                        state_n     = b_entry;
                    end
                    default: begin
                        memReq  = 1'b1;
                        memAddr = (t1_q == T_IND) ? ptr_q : a1_q;
                        waiting = !memAck;
                        if (memAck) begin
                            opa_d   = memRdata;
                            state_n = b_entry;
                        end
                    end
                endcase
            end
            S_B_PTR: begin
                regReadAddr = a2_q[2:0];
                ptr_d       = regReadData[ADDRESS_WIDTH-1:0];
                state_n     = S_B_FETCH;
            end
            S_B_FETCH: begin
                case (t2_q)
                    T_IMM: begin
                        opb_d   = VALUE_WIDTH'(imm_q);
                        state_n = S_EXEC;
                    end
                    T_REG: begin
                        regReadAddr = a2_q[2:0];
                        opb_d       = regReadData;
                        state_n     = S_EXEC;
                    end
                    default: begin
                        memReq  = 1'b1;
                        memAddr = (t2_q == T_IND) ? ptr_q : a2_q;
                        waiting = !memAck;
                        if (memAck) begin
                            opb_d   = memRdata;
                            state_n = S_EXEC;
                        end
                    end
                endcase
            end
            S_EXEC: begin
                // aluDone in the start cycle belongs to nothing we issued
                waiting = start_q || !aluDone;
                if (!start_q && aluDone) begin
                    res_d   = aluResult;
                    state_n = (to_q == T_IND) ? S_W_PTR : S_W_WRITE;
                end
            end
            S_W_PTR: begin
                regReadAddr = ao_q[2:0];
                ptr_d       = regReadData[ADDRESS_WIDTH-1:0];
                state_n     = S_W_WRITE;
            end
            S_W_WRITE: begin
                case (to_q)
                    T_IMM: begin
                        err_ill = 1'b1;
                        state_n = S_IDLE;
                    end
                    T_REG: begin
                        regWe        = 1'b1;
                        regWriteAddr = ao_q[2:0];
                        regWriteData = res_q;
                        state_n      = S_IDLE;
                    end
                    default: begin
                        memReq   = 1'b1;
                        memWe    = 1'b1;
                        memAddr  = (to_q == T_IND) ? ptr_q : ao_q;
                        memWdata = res_q;
                        waiting  = !memAck;
                        if (memAck) begin
                            state_n = S_IDLE;
                        end
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        state_d = timeout ? S_IDLE : state_n;
        start_d = (state_d == S_EXEC) && (state_q != S_EXEC);
    end

`ifdef OPERAND_SEQ_TIMEOUT_EN
    logic [3:0] wdog_q, wdog_d;

    // 15th consecutive waiting cycle aborts the instruction
    assign timeout = waiting && (wdog_q == 4'd14);

    always_comb begin
        wdog_d = wdog_q;
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (waiting) begin
            wdog_d = wdog_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic waiting_unused;
    assign waiting_unused = waiting;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            ao_q    <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            to_q    <= '0;
            imm_q   <= '0;
            ptr_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            ao_q    <= ao_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            to_q    <= to_d;
            imm_q   <= imm_d;
            ptr_q   <= ptr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            start_q <= start_d;
        end
    end

    assign instrReady = (state_q == S_IDLE) && !reset;
    assign busy       = (state_q != S_IDLE);
    assign aluStart   = start_q;
    assign aluOp      = op_q;
    assign opA        = opa_q;
    assign opB        = opb_q;
    assign error      = err_ill || timeout;

endmodule

// File: tb/tb_operand_sequencer.sv
// Scoreboard bench for operand_sequencer: random instructions against an
// array-based model, plus directed latency, wait, indirect, illegal and reset cases.
module tb_operand_sequencer;

    localparam int VW = 16;
    localparam int OW = 6;
    localparam int AW = 8;

    localparam logic [1:0] K_ERR = 2'd0;
    localparam logic [1:0] K_REG = 2'd1;
    localparam logic [1:0] K_MEM = 2'd2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          instrValid = 1'b0;
    logic          instrReady;
    logic [OW-1:0] opCode = '0;
    logic [AW-1:0] address1In = '0, address2In = '0, addressOut = '0;
    logic [1:0]    address1Type = '0, address2Type = '0, outType = '0;
    logic [7:0]    instructionValue = '0;
    logic [2:0]    regReadAddr;
    logic [VW-1:0] regReadData;
    logic          regWe;
    logic [2:0]    regWriteAddr;
    logic [VW-1:0] regWriteData;
    logic          memReq, memWe;
    logic [AW-1:0] memAddr;
    logic [VW-1:0] memWdata;
    logic          memAck = 1'b0;
    logic [VW-1:0] memRdata = '0;
    logic          aluStart;
    logic [OW-1:0] aluOp;
    logic [VW-1:0] opA, opB;
    logic          aluDone = 1'b0;
    logic [VW-1:0] aluResult = '0;
    logic          busy, error;

    operand_sequencer #(.VALUE_WIDTH(VW), .OPCODE_WIDTH(OW), .ADDRESS_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .instrValid(instrValid), .instrReady(instrReady),
        .opCode(opCode),
        .address1In(address1In), .address2In(address2In), .addressOut(addressOut),
        .address1Type(address1Type), .address2Type(address2Type), .outType(outType),
        .instructionValue(instructionValue),
        .regReadAddr(regReadAddr), .regReadData(regReadData),
        .regWe(regWe), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memAck(memAck), .memRdata(memRdata),
        .aluStart(aluStart), .aluOp(aluOp), .opA(opA), .opB(opB),
        .aluDone(aluDone), .aluResult(aluResult),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
    } alu_exp_t;

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [VW-1:0] data;
    } wr_exp_t;

    alu_exp_t alu_q[$];
    wr_exp_t  wr_q[$];

    logic [VW-1:0] rf [8];
    logic [VW-1:0] mem [256];
    logic [VW-1:0] m_rf [8];
    logic [VW-1:0] m_mem [256];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_we_cyc = 0;
    int last_req_len = 0;
    int mem_wait_fix = -1;
    int alu_wait_fix = -1;
    bit no_ack = 1'b0;

    function automatic logic [VW-1:0] rf_init(input int i);
        return VW'(i) * 16'h1111 ^ 16'h00F0;
    endfunction

    function automatic logic [VW-1:0] mem_init(input int i);
        return 16'h1234 + (VW'(i) - 16'd64) * 16'h0107;
    endfunction

    function automatic logic [VW-1:0] alu_f(input logic [OW-1:0] op,
                                            input logic [VW-1:0] a,
                                            input logic [VW-1:0] b);
        logic [VW-1:0] r;
        r = op[0] ? a - b : a + b;
        return r ^ VW'(op[OW-1:1]);
    endfunction

    function automatic logic [VW-1:0] operand(input logic [1:0] t,
                                              input logic [AW-1:0] a,
                                              input logic [VW-1:0] imm);
        case (t)
            2'b00:   return imm;
            2'b01:   return m_rf[a[2:0]];
            2'b10:   return m_mem[a];
            default: return m_mem[m_rf[a[2:0]][AW-1:0]];
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [OW-1:0] op,
                         input logic [1:0] t1, input logic [AW-1:0] a1,
                         input logic [1:0] t2, input logic [AW-1:0] a2,
                         input logic [7:0] iv,
                         input logic [1:0] to, input logic [AW-1:0] ao);
        logic [VW-1:0] va, vb, res;
        logic [AW-1:0] p;
        alu_exp_t x;
        wr_exp_t  w;
        int n;
        n = 0;
        while (!instrReady && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        check("ready_wait", 32'(instrReady), 32'd1);
        va = operand(t1, a1, VW'(a1));
        vb = operand(t2, a2, VW'(iv));
        res = alu_f(op, va, vb);
        x.op = op; x.a = va; x.b = vb;
        alu_q.push_back(x);
        w.kind = K_ERR; w.addr = '0; w.data = '0;
        case (to)
            2'b01: begin
                w.kind = K_REG; w.addr = AW'(ao[2:0]); w.data = res;
                m_rf[ao[2:0]] = res;
            end
            2'b10: begin
                w.kind = K_MEM; w.addr = ao; w.data = res;
                m_mem[ao] = res;
            end
            2'b11: begin
                p = m_rf[ao[2:0]][AW-1:0];
                w.kind = K_MEM; w.addr = p; w.data = res;
                m_mem[p] = res;
            end
            default: ;
        endcase
        wr_q.push_back(w);
        opCode = op;
        address1Type = t1; address1In = a1;
        address2Type = t2; address2In = a2;
        instructionValue = iv;
        outType = to; addressOut = ao;
        instrValid = 1'b1;
        @(posedge clock); #1;
        instrValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((alu_q.size() != 0 || wr_q.size() != 0 || !instrReady) && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("drain", 32'(alu_q.size() + wr_q.size()), 32'd0);
    endtask

    assign regReadData = rf[regReadAddr];

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // memory responder
    initial begin
        bit            active;
        int            wl, req_len;
        logic [AW-1:0] s_addr;
        logic          s_we;
        logic [VW-1:0] s_wd;
        active = 1'b0; wl = 0; req_len = 0;
        s_addr = '0; s_we = 1'b0; s_wd = '0;
        for (int i = 0; i < 256; i++) mem[i] = mem_init(i);
        forever begin
            @(posedge clock); #1;
            memAck = 1'b0;
            if (reset || !memReq) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    req_len = 0;
                    s_addr = memAddr; s_we = memWe; s_wd = memWdata;
                    wl = (mem_wait_fix >= 0) ? mem_wait_fix : int'($urandom_range(0, 3));
                end else begin
                    check("mem_hold_addr", 32'(memAddr), 32'(s_addr));
                    check("mem_hold_we", 32'(memWe), 32'(s_we));
                    check("mem_hold_wdata", 32'(memWdata), 32'(s_wd));
                end
                req_len++;
                if (!no_ack) begin
                    if (wl == 0) begin
                        memAck = 1'b1;
                        last_req_len = req_len;
                        if (memWe) mem[memAddr] = memWdata;
                        else memRdata = mem[memAddr];
                        active = 1'b0;
                    end else begin
                        wl--;
                    end
                end
            end
        end
    end

    // ALU responder
    initial begin
        bit pend;
        int wl;
        pend = 1'b0; wl = 0;
        forever begin
            @(posedge clock); #1;
            aluDone = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (wl == 0) begin
                        aluDone = 1'b1;
                        aluResult = alu_f(aluOp, opA, opB);
                        pend = 1'b0;
                    end else begin
                        wl--;
                    end
                end
                if (aluStart) begin
                    pend = 1'b1;
                    wl = (alu_wait_fix >= 0) ? alu_wait_fix : int'($urandom_range(0, 2));
                end
            end
        end
    end

    // monitor
    initial begin
        alu_exp_t      ae;
        wr_exp_t       we;
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [VW-1:0] data;
        for (int i = 0; i < 8; i++) rf[i] = rf_init(i);
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (instrValid && instrReady) acc_cyc = cyc;
                if (aluStart) begin
                    if (alu_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL alu_start: got unexpected start, required none");
                    end else begin
                        ae = alu_q.pop_front();
                        check("aluOp", 32'(aluOp), 32'(ae.op));
                        check("opA", 32'(opA), 32'(ae.a));
                        check("opB", 32'(opB), 32'(ae.b));
                    end
                end
                if (regWe || error || (memReq && memWe && memAck)) begin
                    kind = error ? K_ERR : (regWe ? K_REG : K_MEM);
                    addr = regWe ? AW'(regWriteAddr) : memAddr;
                    data = regWe ? regWriteData : memWdata;
                    if (wr_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL wb_event: got unexpected kind %0d, required none", kind);
                    end else begin
                        we = wr_q.pop_front();
                        check("wb_kind", 32'(kind), 32'(we.kind));
                        if (we.kind != K_ERR) begin
                            check("wb_addr", 32'(addr), 32'(we.addr));
                            check("wb_data", 32'(data), 32'(we.data));
                        end else begin
                            check("err_no_write", {30'd0, regWe, memWe}, 32'd0);
                        end
                    end
                    if (regWe) begin
                        rf[regWriteAddr] = regWriteData;
                        last_we_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n, cnt;
        for (int i = 0; i < 8; i++) m_rf[i] = rf_init(i);
        for (int i = 0; i < 256; i++) m_mem[i] = mem_init(i);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", 32'(|{instrReady, regReadAddr, regWe, regWriteAddr,
              regWriteData, memReq, memWe, memAddr, memWdata, aluStart, aluOp,
              opA, opB, busy, error}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", 32'(instrReady), 32'd1);
        @(posedge clock); #1;

        // imm/imm/reg, minimum latency
        alu_wait_fix = 0;
        issue(6'd0, 2'b00, 8'h05, 2'b00, 8'h00, 8'h03, 2'b01, 8'd2);
        drain();
        check("min_latency", 32'(last_we_cyc - acc_cyc), 32'd5);
        check("rf2_value", 32'(rf[2]), 32'h0008);

        // direct memory A with three wait cycles
        mem_wait_fix = 3;
        issue(6'd0, 2'b10, 8'h40, 2'b00, 8'h00, 8'h01, 2'b01, 8'd3);
        drain();
        check("memreq_len", 32'(last_req_len), 32'd4);
        mem_wait_fix = -1;

        // r4 = 0x0080, then indirect destination through r4
        issue(6'd0, 2'b00, 8'h80, 2'b00, 8'h00, 8'h00, 2'b01, 8'd4);
        issue(6'd1, 2'b01, 8'd4, 2'b00, 8'h00, 8'h10, 2'b11, 8'd4);
        drain();
        check("ind_mem_value", 32'(mem[8'h80]), 32'h0070);

        // illegal destination
        issue(6'd2, 2'b00, 8'h11, 2'b00, 8'h00, 8'h22, 2'b00, 8'd5);
        drain();
        @(negedge clock);
        check("ready_after_err", 32'(instrReady), 32'd1);
        alu_wait_fix = -1;

        for (int k = 0; k < 60; k++) begin
            issue(OW'($urandom), 2'($urandom), 8'($urandom), 2'($urandom),
                  8'($urandom), 8'($urandom), 2'($urandom), 8'($urandom));
        end
        drain();

        // reset during a stalled B fetch
        no_ack = 1'b1;
        issue(6'd0, 2'b00, 8'h01, 2'b10, 8'h33, 8'h00, 2'b00, 8'd0);
        n = 0;
        while (!memReq && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("bfetch_memreq", 32'(memReq), 32'd1);
        reset = 1'b1;
        alu_q.delete();
        wr_q.delete();
        @(posedge clock);
        @(negedge clock);
        check("midreset_outputs", 32'(|{instrReady, regReadAddr, regWe, regWriteAddr,
              regWriteData, memReq, memWe, memAddr, memWdata, aluStart, aluOp,
              opA, opB, busy, error}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        no_ack = 1'b0;
        #1;
        memAck = 1'b1;
        @(negedge clock);
        check("stray_ack_ready", 32'(instrReady), 32'd1);
        @(negedge clock);
        check("stray_ack_idle", {30'd0, busy, memReq}, 32'd0);

`ifdef OPERAND_SEQ_TIMEOUT_EN
        no_ack = 1'b1;
        issue(6'd0, 2'b10, 8'h22, 2'b00, 8'h00, 8'h00, 2'b00, 8'd0);
        alu_q.delete();
        n = 0;
        cnt = 0;
        while (!error && n < 40) begin
            @(negedge clock);
            if (memReq) cnt++;
            n++;
        end
        check("timeout_cycles", 32'(cnt), 32'd15);
        @(negedge clock);
        check("timeout_idle", {30'd0, busy, memReq}, 32'd0);
        no_ack = 1'b0;
`else
        cnt = 0;
`endif

        // sequencer still operational afterwards
        issue(6'd0, 2'b00, 8'h07, 2'b00, 8'h00, 8'h09, 2'b01, 8'd6);
        drain();
        check("final_queue_cnt", 32'(cnt * 0 + wr_q.size()), 32'd0);

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
